// File: rtl/usr_pkg.sv
// Shared definitions for the serial transmit controller and its shift register:
// shift-register mode encoding and controller FSM states.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/usr_tx_ctrl_if.sv
// Upstream word handshake and downstream serial-bit handshake of usr_tx_ctrl.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface usr_tx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             in_fill;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_ready;

    modport slave (
        input  in_valid, in_data, in_dir, in_fill, tx_ready,
        output in_ready, tx_bit, tx_valid
    );

    modport master (
        output in_valid, in_data, in_dir, in_fill, tx_ready,
        input  in_ready, tx_bit, tx_valid
    );
endinterface

// File: rtl/four_bit_shift_reg.sv
// Universal shift register driven by usr_tx_ctrl: hold, shift right, shift left, parallel load.
module FourBit_ShiftReg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] BlockIn,
    input  logic             serialIn,
    output logic [WIDTH-1:0] reg_out
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        unique case (sel)
            SEL_RIGHT: q_d = {serialIn, q_q[WIDTH-1:1]};
            SEL_LEFT:  q_d = {q_q[WIDTH-2:0], serialIn};
            SEL_LOAD:  q_d = BlockIn;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign reg_out = q_q;
endmodule

// File: rtl/usr_bit_counter.sv
// Counts transferred bits of one word; tc flags the last bit position (WIDTH-1).
module usr_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/usr_tx_ctrl.sv
// Serialises a parallel word through an external universal shift register,
// offering one bit per valid/ready transfer and pulsing done after the last one.
module usr_tx_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    usr_tx_ctrl_if.slave     bus,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] BlockIn,
    output logic             serialIn,
    input  logic [WIDTH-1:0] reg_out,
    output logic             done,
    output state_e           state_dbg
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             in_ready, tx_valid;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [IW-1:0]    tx_idx;

    usr_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        dir_d    = dir_q;
        fill_d   = fill_q;
        sel      = SEL_HOLD;
        in_ready = 1'b0;
        tx_valid = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    dir_d   = bus.in_dir;
                    fill_d  = bus.in_fill;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sel     = SEL_LOAD;
                cnt_clr = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                tx_valid = 1'b1;
                // A stalled bit keeps the register on hold so tx_bit stays put.
                if (bus.tx_ready) begin
                    sel    = dir_q ? SEL_LEFT : SEL_RIGHT;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

    // The bit leaving the register is the end it shifts out of.
    assign tx_idx       = dir_q ? IW'(WIDTH - 1) : '0;
    assign bus.tx_bit   = reg_out[tx_idx];
    assign bus.tx_valid = tx_valid;
    assign bus.in_ready = in_ready;
    assign BlockIn      = word_q;
    assign serialIn     = fill_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_usr_tx_ctrl.sv
// Directed bench: usr_tx_ctrl driving FourBit_ShiftReg with reg_out fed back, WIDTH=4.
module tb_usr_tx_ctrl;
    import usr_pkg::*;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic [1:0]     sel;
    logic [W-1:0]   block_in;
    logic           serial_in;
    logic [W-1:0]   reg_out;
    logic           done;
    state_e         state_dbg;

    usr_tx_ctrl_if #(.WIDTH(W)) bus ();

    usr_tx_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sel       (sel),
        .BlockIn   (block_in),
        .serialIn  (serial_in),
        .reg_out   (reg_out),
        .done      (done),
        .state_dbg (state_dbg)
    );

    FourBit_ShiftReg #(.WIDTH(W)) u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .BlockIn  (block_in),
        .serialIn (serial_in),
        .reg_out  (reg_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        logic         fill;
        logic [W-1:0] seq;   // seq[0] is the first bit expected on tx_bit
        logic [W-1:0] fin;
        int           stall_after;
        int           stall_len;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with the controller in IDLE; returns
    // just after the falling edge of the IDLE cycle following DONE.
    task automatic run_xfer(input vec_t v);
        logic exp_sel;
        for (int i = 0; i < W; i++) exp_q.push_back(v.seq[i]);
        bus.in_data  = v.data;
        bus.in_dir   = v.dir;
        bus.in_fill  = v.fill;
        bus.tx_ready = 1'b1;
        bus.in_valid = 1'b1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_sel", 32'(sel), 32'(SEL_HOLD));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("load_sel", 32'(sel), 32'(SEL_LOAD));
        check("load_blockin", 32'(block_in), 32'(v.data));
        check("load_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("load_in_ready", 32'(bus.in_ready), 32'd0);
        exp_sel = v.dir;
        for (int i = 0; i < W; i++) begin
            if (i == v.stall_after) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    @(negedge clk);
                    bus.tx_ready = 1'b0;
                    #1;
                    check("stall_sel", 32'(sel), 32'(SEL_HOLD));
                    check("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
                    check("stall_tx_bit", 32'(bus.tx_bit), 32'(exp_q[0]));
                end
            end
            @(negedge clk);
            bus.tx_ready = 1'b1;
            #1;
            check("shift_tx_valid", 32'(bus.tx_valid), 32'd1);
            check("shift_tx_bit", 32'(bus.tx_bit), 32'(exp_q.pop_front()));
            check("shift_sel", 32'(sel), exp_sel ? 32'(SEL_LEFT) : 32'(SEL_RIGHT));
            check("shift_serial_in", 32'(serial_in), 32'(v.fill));
        end
        @(negedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("done_sel", 32'(sel), 32'(SEL_HOLD));
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        check("final_reg_out", 32'(reg_out), 32'(v.fin));
        @(negedge clk);
        #1;
        check("post_done_low", 32'(done), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'(SEL_HOLD));
        check({tag, "_blockin"}, 32'(block_in), 32'd0);
        check({tag, "_serial_in"}, 32'(serial_in), 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_tx_bit"}, 32'(bus.tx_bit), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        vecs[0] = '{data: 4'b1001, dir: 1'b0, fill: 1'b0, seq: 4'b1001, fin: 4'b0000, stall_after: 99, stall_len: 0};
        vecs[1] = '{data: 4'b1101, dir: 1'b1, fill: 1'b1, seq: 4'b1011, fin: 4'b1111, stall_after: 99, stall_len: 0};
        vecs[2] = '{data: 4'b0110, dir: 1'b0, fill: 1'b0, seq: 4'b0110, fin: 4'b0000, stall_after: 2,  stall_len: 3};
        vecs[3] = '{data: 4'b0011, dir: 1'b1, fill: 1'b0, seq: 4'b1100, fin: 4'b0000, stall_after: 99, stall_len: 0};
        vecs[4] = '{data: 4'b0101, dir: 1'b0, fill: 1'b1, seq: 4'b0101, fin: 4'b1111, stall_after: 99, stall_len: 0};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dir   = 1'b0;
        bus.in_fill  = 1'b0;
        bus.tx_ready = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int k = 0; k < 5; k++) run_xfer(vecs[k]);

        // Reset during the third bit of 1100 (dir=0): bits 0,0,1,...
        bus.in_data  = 4'b1100;
        bus.in_dir   = 1'b0;
        bus.in_fill  = 1'b0;
        bus.tx_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre_reset_tx_bit", 32'(bus.tx_bit), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("reset_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_xfer('{data: 4'b1010, dir: 1'b0, fill: 1'b0, seq: 4'b1010, fin: 4'b0000, stall_after: 99, stall_len: 0});

        // in_valid held high: accepts only from IDLE, every WIDTH+3 cycles.
        bus.in_data  = 4'b0011;
        bus.in_dir   = 1'b0;
        bus.in_fill  = 1'b0;
        bus.tx_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            check("cont_in_ready", 32'(bus.in_ready), 32'((cyc % 7) == 0));
            check("cont_done", 32'(done), 32'((cyc % 7) == 6));
            @(negedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("cont_end_idle", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #1;
        check("cont_no_accept", 32'(state_dbg), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/usr_tx_ctrl.md
USR_TX_CTRL -- requirements
Module: usr_tx_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the parallel word and of the driven shift register; the transfer length in bits.
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a parallel word is offered.
REQ-005 in_ready  output  1  controller accepts a word this cycle.
REQ-006 in_data  input  WIDTH  word to serialise.
REQ-007 in_dir  input  1  0 = shift right (bit 0 leaves first); 1 = shift left (bit WIDTH-1 leaves first); sampled with in_data.
REQ-008 in_fill  input  1  bit shifted into the vacated end; sampled with in_data.
REQ-009 sel  output  2  shift-register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-010 BlockIn  output  WIDTH  parallel load value for the shift register.
REQ-011 serialIn  output  1  serial fill bit for the shift register.
REQ-012 reg_out  input  WIDTH  feedback from the shift register parallel output.
REQ-013 tx_bit  output  1  current serial bit offered downstream.
REQ-014 tx_valid  output  1  tx_bit is valid.
REQ-015 tx_ready  input  1  downstream consumes tx_bit when tx_valid is also high.
REQ-016 done  output  1  one-cycle pulse after the last bit transfers.

Function
REQ-017 FSM states: IDLE, LOAD, SHIFT, DONE; held in a state register with a bit counter of width $clog2(WIDTH+1).
REQ-018 IDLE: in_ready=1, sel=00; in_valid=1 latches in_data, in_dir, in_fill -> LOAD.
REQ-019 LOAD lasts exactly one cycle: sel=11, BlockIn=latched word, in_ready=0, tx_valid=0; next state SHIFT, counter cleared to 0.
REQ-020 SHIFT: tx_valid=1; tx_bit=reg_out[0] when dir=0, reg_out[WIDTH-1] when dir=1; serialIn=latched fill.
REQ-021 SHIFT with tx_ready=1: sel=01 (dir=0) or 10 (dir=1), counter increments; with tx_ready=0: sel=00, tx_bit and counter stable.
REQ-022 A transfer with counter=WIDTH-1 is the last transfer -> DONE; tx_valid=0 in DONE.
REQ-023 DONE lasts one cycle: done=1, sel=00, in_ready=0; then -> IDLE; in_valid during DONE is not accepted.
REQ-024 Latency: accept at edge N; LOAD cycle N+1; first tx_valid cycle N+2; with tx_ready held at 1, done high in cycle N+2+WIDTH.
REQ-025 sel, tx_valid, in_ready, done are combinational from state and tx_ready only; BlockIn and serialIn are registered holding values.
REQ-026 Back-to-back words: minimum spacing between accepts is WIDTH+3 cycles; no overlap of transfers.

Reset
REQ-027 Reset low forces immediately: state IDLE, counter 0, latched word/dir/fill 0.
REQ-028 Reset-asserted outputs: sel=00, BlockIn=0, serialIn=0, tx_valid=0, done=0, tx_bit=reg_out[0], in_ready=1.
REQ-029 Reset mid-transfer discards the word; no done pulse; first accept possible on the first edge after release.

Structure
REQ-030 Shared package usr_pkg holds the sel encoding constants (SEL_HOLD, SEL_RIGHT, SEL_LEFT, SEL_LOAD) and the FSM state enum; FourBit_ShiftReg consumers use the same constants.
REQ-031 One sub-module, usr_bit_counter (clear, enable, terminal-count flag at WIDTH-1); all else in usr_tx_ctrl.

Verification
REQ-032 Bench instantiates usr_tx_ctrl driving FourBit_ShiftReg with reg_out fed back; WIDTH=4.
REQ-033 in_data=1001, dir=0, fill=0, tx_ready=1 -> tx_bit 1,0,0,1 on four consecutive cycles; final reg_out=0000; done 6 cycles after accept.
REQ-034 in_data=1101, dir=1, fill=1, tx_ready=1 -> tx_bit 1,1,0,1; final reg_out=1111; done pulse one cycle.
REQ-035 in_data=0110, dir=0, tx_ready low for 3 cycles after second bit -> sel=00 and tx_bit=1 held for 3 cycles; sequence 0,1,1,0 intact.
REQ-036 Reset pulsed low during third bit -> outputs at reset values same cycle; no done; new word 1010 after release transfers 0,1,0,1 (dir=0).
REQ-037 in_valid held high continuously -> in_ready high only in IDLE; accepts spaced exactly 7 cycles apart.
